parity_alarm_monitor: RTL

Collects the per-word `alarm` outputs of the parity-protected pipeline memories and turns them into an ordered stream of error reports. Every source gets a sticky pending flag and an error-cycle counter. A round-robin arbiter presents one report at a time over a valid/ready handshake, and raises a level interrupt. It sits at the top level, beside the adder chain, and consumes the `alarm_signals` bus.

---
 rtl/alarm_mon_pkg.sv | 23 ++
 rtl/parity_alarm_monitor_rr_pick.sv | 35 +++
 rtl/parity_alarm_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alarm_mon_pkg.sv
// Shared types for parity_alarm_monitor: FSM state and the report record.
// Report fields are sized for up to 256 sources and 32-bit counters.
package alarm_mon_pkg;

    localparam int MON_SRC_W = 8;
    localparam int MON_CNT_W = 32;

    typedef enum logic {
        MON_IDLE   = 1'b0,
        MON_REPORT = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic [MON_SRC_W-1:0] src;
        logic [MON_CNT_W-1:0] count;
        logic                 ovf;
    } mon_report_t;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_alarm_monitor_rr_pick.sv
// Round-robin first-set-bit selector: lowest set request at or above ptr_i,
// wrapping past N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] idx_o,
    output logic          found_o
);

    localparam int SW1 = SW + 1;

    logic [N-1:0] rot;
    logic [SW:0]  sum;

    // Rotate so bit 0 of rot is the request at ptr_i.
    assign rot = N'({req_i, req_i} >> ptr_i);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + SW1'(k);
                if (sum >= SW1'(N)) sum = sum - SW1'(N);
                idx_o   = sum[SW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_alarm_monitor.sv
// Parity alarm collector: sticky pending flags, per-source error counters and a
// round-robin valid/ready report stream. ALARM_MON_OVERFLOW_EN adds saturating counters.
module parity_alarm_monitor
    import alarm_mon_pkg::*;
#(
    parameter  int NUM_SRC   = 8,
    parameter  int CNT_WIDTH = 8,
    localparam int SW        = src_w(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   alarm_in,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 report_valid,
    input  logic                 report_ready,
    output logic [SW-1:0]        report_src,
    output logic [CNT_WIDTH-1:0] report_count,
    output logic                 report_ovf,
    output logic                 irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [SW-1:0]        SRC_ONE = SW'(1);
    localparam logic [SW-1:0]        SRC_TOP = SW'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]                alarm_q, hit;
    logic [NUM_SRC-1:0]                pend_q, pend_d;
    logic [NUM_SRC-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]              base;
    logic [SW-1:0]                     rr_ptr_q, pick_idx, sel;
    logic                              pick_found, hs, irq_q, pick_ovf;
    mon_state_e                        state_q;
    mon_report_t                       rep_q;
    logic                              unused_rep;

`ifdef ALARM_MON_OVERFLOW_EN
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
`endif

    assign hit = enable ? alarm_q : '0;
    assign hs  = (state_q == MON_REPORT) && report_ready;
    assign sel = rep_q.src[SW-1:0];

    rr_pick #(.N(NUM_SRC), .SW(SW)) u_pick (
        .req_i   (pend_q),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        base   = '0;
`ifdef ALARM_MON_OVERFLOW_EN
        ovf_d  = ovf_q;
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hit[i]) begin
                pend_d[i] = 1'b1;
`ifdef ALARM_MON_OVERFLOW_EN
                if (&cnt_q[i]) ovf_d[i] = 1'b1;
                else           cnt_d[i] = cnt_q[i] + CNT_ONE;
`else
                cnt_d[i] = cnt_q[i] + CNT_ONE;
`endif
            end
            // Keep whatever accrued while the report was on the wire.
            if (hs && (SW'(i) == sel)) begin
`ifdef ALARM_MON_OVERFLOW_EN
                base     = ovf_q[i] ? '0 : cnt_q[i] - rep_q.count[CNT_WIDTH-1:0];
                ovf_d[i] = 1'b0;
`else
                base     = cnt_q[i] - rep_q.count[CNT_WIDTH-1:0];
`endif
                cnt_d[i]  = base + CNT_WIDTH'(hit[i]);
                pend_d[i] = |cnt_d[i];
            end
        end
        if (clear) begin
            pend_d = '0;
            cnt_d  = '0;
`ifdef ALARM_MON_OVERFLOW_EN
            ovf_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            alarm_q <= alarm_in;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            irq_q   <= |pend_d;
        end
    end

`ifdef ALARM_MON_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end
    assign pick_ovf   = ovf_q[pick_idx];
    assign report_ovf = rep_q.ovf;
`else
    assign pick_ovf   = 1'b0;
    assign report_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MON_IDLE;
            rep_q    <= '0;
            rr_ptr_q <= '0;
        end else if (clear) begin
            state_q <= MON_IDLE;
        end else begin
            case (state_q)
                MON_IDLE: begin
                    if (pick_found) begin
                        rep_q.src   <= MON_SRC_W'(pick_idx);
                        rep_q.count <= MON_CNT_W'(cnt_q[pick_idx]);
                        rep_q.ovf   <= pick_ovf;
                        state_q     <= MON_REPORT;
                    end
                end
                MON_REPORT: begin
                    if (report_ready) begin
                        rr_ptr_q <= (sel == SRC_TOP) ? '0 : sel + SRC_ONE;
                        state_q  <= MON_IDLE;
                    end
                end
                default: state_q <= MON_IDLE;
            endcase
        end
    end

    assign report_valid = (state_q == MON_REPORT);
    assign report_src   = rep_q.src[SW-1:0];
    assign report_count = rep_q.count[CNT_WIDTH-1:0];
    assign irq          = irq_q;
    assign unused_rep   = ^rep_q;

endmodule
